// File: rtl/sfp_accum_act_if.sv
// rtl/sfp_accum_act_if.sv - psum input stream and result output handshake bundle
interface sfp_accum_act_if #(
  parameter int psum_bw = 16,
  parameter int col     = 8
);
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic [psum_bw*col-1:0]   sfp_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [psum_bw*col-1:0]   sfp_out;

  modport master (
    output in_valid, in_last, sfp_in, out_ready,
    input  in_ready, out_valid, sfp_out
  );

  modport slave (
    input  in_valid, in_last, sfp_in, out_ready,
    output in_ready, out_valid, sfp_out
  );
endinterface

// File: rtl/sfp_accum_act.sv
// rtl/sfp_accum_act.sv - saturating per-channel psum accumulator with optional ReLU and output hold
module sfp_accum_act #(
  parameter int                         psum_bw = 16,
  parameter int                         col     = 8,
  parameter logic signed [psum_bw-1:0]  thres   = '0,
  parameter int                         cnt_bw  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              relu_en,
  sfp_accum_act_if.slave    s,
  output logic [col-1:0]    sat_flag,
  output logic [cnt_bw-1:0] beat_cnt
);

  typedef enum logic [1:0] {IDLE, ACC, ACT, HOLD} state_t;

  localparam logic signed [psum_bw-1:0] max_v = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] min_v = {1'b1, {(psum_bw-1){1'b0}}};

  state_t                    state;
  logic signed [psum_bw-1:0] acc     [col];
  logic signed [psum_bw-1:0] acc_nxt [col];
  logic        [psum_bw:0]   sum     [col];
  logic        [col-1:0]     sat_nxt;
  logic                      accept;

  assign s.in_ready = (state == IDLE) || (state == ACC);
  assign accept     = s.in_valid && s.in_ready;

  // One extra bit of headroom: the top two bits disagree exactly on overflow.
  always_comb begin
    sat_nxt = '0;
    for (int k = 0; k < col; k++) begin
      sum[k] = {acc[k][psum_bw-1], acc[k]} +
               {s.sfp_in[psum_bw*(k+1)-1], s.sfp_in[k*psum_bw +: psum_bw]};
      if (sum[k][psum_bw] != sum[k][psum_bw-1]) begin
        sat_nxt[k] = 1'b1;
        acc_nxt[k] = sum[k][psum_bw] ? min_v : max_v;
      end else begin
        acc_nxt[k] = sum[k][psum_bw-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state       <= IDLE;
      s.out_valid <= 1'b0;
      s.sfp_out   <= '0;
      sat_flag    <= '0;
      beat_cnt    <= '0;
      for (int k = 0; k < col; k++) acc[k] <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            for (int k = 0; k < col; k++) acc[k] <= acc_nxt[k];
            sat_flag <= sat_flag | sat_nxt;
            if (beat_cnt != '1) beat_cnt <= beat_cnt + cnt_bw'(1);
            state <= s.in_last ? ACT : ACC;
          end
        end
        ACT: begin
          for (int k = 0; k < col; k++)
            s.sfp_out[k*psum_bw +: psum_bw] <= (relu_en && !(acc[k] > thres)) ? '0 : acc[k];
          s.out_valid <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (s.out_ready) begin
            s.out_valid <= 1'b0;
            sat_flag    <= '0;
            beat_cnt    <= '0;
            for (int k = 0; k < col; k++) acc[k] <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_accum_act.sv
// tb/tb_sfp_accum_act.sv - scoreboard bench for sfp_accum_act at thresholds 0 and 3
module tb_sfp_accum_act;
  localparam int W = 128;

  logic       clk = 1'b0;
  logic       reset, clr, relu_en;
  logic [7:0] sat0, sat3, cnt0, cnt3;

  sfp_accum_act_if #(.psum_bw(16), .col(8)) bus0 ();
  sfp_accum_act_if #(.psum_bw(16), .col(8)) bus3 ();

  sfp_accum_act #(.psum_bw(16), .col(8), .thres(16'sd0), .cnt_bw(8)) u_dut0 (
    .clk(clk), .reset(reset), .clr(clr), .relu_en(relu_en),
    .s(bus0.slave), .sat_flag(sat0), .beat_cnt(cnt0)
  );

  sfp_accum_act #(.psum_bw(16), .col(8), .thres(16'sd3), .cnt_bw(8)) u_dut3 (
    .clk(clk), .reset(reset), .clr(clr), .relu_en(relu_en),
    .s(bus3.slave), .sat_flag(sat3), .beat_cnt(cnt3)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         m_acc [8];
  logic [7:0] m_sat;
  int         m_cnt;
  logic [W-1:0] beat_v;
  logic [W-1:0] last_e0;
  logic [W-1:0] q_out0 [$];
  logic [W-1:0] q_out3 [$];
  logic [7:0]   q_sat  [$];
  int           q_cnt  [$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic last, input logic [W-1:0] d);
    bus0.in_valid = v; bus3.in_valid = v;
    bus0.in_last  = last; bus3.in_last = last;
    bus0.sfp_in   = d; bus3.sfp_in = d;
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus3.out_ready = r;
  endtask

  task automatic model_clear;
    for (int k = 0; k < 8; k++) m_acc[k] = 0;
    m_sat = '0;
    m_cnt = 0;
  endtask

  task automatic set_ch(input int k, input int val);
    beat_v[k*16 +: 16] = 16'(val);
  endtask

  function automatic logic [W-1:0] relu_vec(input int t);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++)
      r[k*16 +: 16] = (relu_en && !(m_acc[k] > t)) ? 16'd0 : 16'(m_acc[k]);
    return r;
  endfunction

  task automatic beat(input logic last);
    int v, t;
    chk("in_ready_beat", W'(bus0.in_ready), W'(1));
    drive(1'b1, last, beat_v);
    tick;
    drive(1'b0, 1'b0, '0);
    for (int k = 0; k < 8; k++) begin
      v = $signed(beat_v[k*16 +: 16]);
      t = m_acc[k] + v;
      if (t > 32767) begin t = 32767; m_sat[k] = 1'b1; end
      if (t < -32768) begin t = -32768; m_sat[k] = 1'b1; end
      m_acc[k] = t;
    end
    if (m_cnt < 255) m_cnt++;
    if (last) begin
      q_out0.push_back(relu_vec(0));
      q_out3.push_back(relu_vec(3));
      q_sat.push_back(m_sat);
      q_cnt.push_back(m_cnt);
    end
  endtask

  task automatic expect_out;
    logic [W-1:0] e3;
    logic [7:0]   es;
    int           ec;
    chk("out_valid_act", W'(bus0.out_valid), W'(0));
    tick;
    chk("out_valid_hold", W'(bus0.out_valid), W'(1));
    chk("in_ready_hold", W'(bus0.in_ready), W'(0));
    tests++;
    assert (q_out0.size() > 0) else begin
      fails++;
      $error("FAIL sb_empty observed=%0d expected=1", q_out0.size());
    end
    if (q_out0.size() > 0) begin
      last_e0 = q_out0.pop_front();
      e3 = q_out3.pop_front();
      es = q_sat.pop_front();
      ec = q_cnt.pop_front();
      chk("sfp_out_t0", bus0.sfp_out, last_e0);
      chk("sfp_out_t3", bus3.sfp_out, e3);
      chk("sat_flag", W'(sat0), W'(es));
      chk("beat_cnt", W'(cnt0), W'(ec));
    end
  endtask

  task automatic release_out;
    set_ready(1'b1);
    tick;
    set_ready(1'b0);
    chk("out_valid_drop", W'(bus0.out_valid), W'(0));
    chk("in_ready_idle", W'(bus0.in_ready), W'(1));
    chk("beat_cnt_clear", W'(cnt0), W'(0));
    model_clear;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; relu_en = 1'b0;
    drive(1'b0, 1'b0, '0);
    set_ready(1'b0);
    model_clear;
    tick; tick;
    reset = 1'b0;
    chk("rst_out_valid", W'(bus0.out_valid), W'(0));
    chk("rst_sfp_out", bus0.sfp_out, '0);
    chk("rst_sat", W'(sat0), W'(0));
    chk("rst_cnt", W'(cnt0), W'(0));
    chk("rst_in_ready", W'(bus0.in_ready), W'(1));

    // reset mid-frame discards the partial accumulation
    beat_v = '0; set_ch(0, 100); set_ch(5, -7);
    beat(1'b0);
    chk("mid_cnt", W'(cnt0), W'(1));
    reset = 1'b1; tick; tick; reset = 1'b0;
    model_clear;
    chk("rst2_out_valid", W'(bus0.out_valid), W'(0));
    chk("rst2_sfp_out", bus0.sfp_out, '0);
    chk("rst2_cnt", W'(cnt0), W'(0));
    chk("rst2_in_ready", W'(bus0.in_ready), W'(1));
    beat_v = '0; set_ch(0, 1);
    beat(1'b1);
    expect_out;
    chk("rst2_residue", bus0.sfp_out, W'(1));
    release_out;

    // three-beat frame with ReLU at threshold 0
    relu_en = 1'b1;
    beat_v = '0; set_ch(0, 5);  set_ch(1, -10); beat(1'b0);
    beat_v = '0; set_ch(0, -2); set_ch(1, 3);   beat(1'b0);
    beat_v = '0; set_ch(0, 4);  set_ch(1, 1);   beat(1'b1);
    expect_out;
    chk("t2_direct", bus0.sfp_out, W'(7));
    chk("t2_cnt", W'(cnt0), W'(3));
    release_out;

    // saturation both directions
    relu_en = 1'b0;
    beat_v = '0; set_ch(2, 30000); set_ch(3, -30000); beat(1'b0);
    beat_v = '0; set_ch(2, 10000); set_ch(3, -10000); beat(1'b1);
    expect_out;
    chk("t3_sat", W'(sat0), W'(8'b00001100));
    chk("t3_ch2", W'(bus0.sfp_out[47:32]), W'(16'h7fff));
    chk("t3_ch3", W'(bus0.sfp_out[63:48]), W'(16'h8000));
    release_out;

    // back-pressure: output stable and input beats ignored in HOLD
    beat_v = '0; set_ch(4, 1234); beat(1'b1);
    expect_out;
    drive(1'b1, 1'b1, {8{16'h1111}});
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_sfp_out", bus0.sfp_out, last_e0);
      chk("bp_out_valid", W'(bus0.out_valid), W'(1));
      chk("bp_in_ready", W'(bus0.in_ready), W'(0));
    end
    drive(1'b0, 1'b0, '0);
    release_out;
    beat_v = '0; set_ch(0, 2); beat(1'b1);
    expect_out;
    chk("bp_no_residue", bus0.sfp_out, W'(2));
    release_out;

    // single-beat frame, threshold 3 instance
    relu_en = 1'b1;
    beat_v = '0; set_ch(0, 3); set_ch(1, 4); beat(1'b1);
    expect_out;
    chk("t5_thres3", W'(bus3.sfp_out[31:0]), W'({16'd4, 16'd0}));
    chk("t5_thres0", W'(bus0.sfp_out[31:0]), W'({16'd4, 16'd3}));
    release_out;

    // clr in HOLD discards the frame
    relu_en = 1'b0;
    beat_v = '0; set_ch(0, 50); beat(1'b1);
    expect_out;
    clr = 1'b1; tick; clr = 1'b0;
    model_clear;
    chk("clr_out_valid", W'(bus0.out_valid), W'(0));
    chk("clr_sfp_out", bus0.sfp_out, '0);
    chk("clr_in_ready", W'(bus0.in_ready), W'(1));
    chk("clr_cnt", W'(cnt0), W'(0));
    beat_v = '0; set_ch(0, 9); beat(1'b1);
    expect_out;
    chk("clr_next", bus0.sfp_out, W'(9));
    release_out;

    // beat counter saturates instead of wrapping
    beat_v = '0; set_ch(6, 1);
    for (int i = 0; i < 299; i++) beat(1'b0);
    beat(1'b1);
    expect_out;
    chk("cnt_sat", W'(cnt0), W'(255));
    chk("cnt_sat_ch6", W'(bus0.sfp_out[111:96]), W'(16'd300));
    release_out;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sfp_accum_act.md
Name: sfp_accum_act

Overview:
Parametrised special-function stage that sits between the OFIFO psum drain and the output SRAM write port.
- Accumulates `col` signed partial sums per channel over a variable number of beats, with saturation.
- Applies an optional per-channel ReLU against a threshold.
- Presents the result behind a valid/ready handshake.
- Generalises the fixed 8-channel wrap-around accumulator with always-on ReLU: generic channel count, saturation, beat counting, explicit framing and output back-pressure.

Parameters:
psum_bw, 16, width of each signed channel psum and accumulator
col, 8, number of channels (any value >= 1)
thres, 0, signed psum_bw threshold for ReLU (pass if acc > thres, else 0)
cnt_bw, 8, width of beat counter

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high; forces IDLE and zeroes all state
clr  input  1  synchronous abort; same effect as reset; lower priority than reset, higher than everything else
in_valid  input  1  sfp_in beat valid
in_last  input  1  marks final beat of a frame; qualified by in_valid
in_ready  output  1  block can accept a beat
sfp_in  input  psum_bw*col  packed signed psums, channel k at [psum_bw*(k+1)-1 : psum_bw*k]
relu_en  input  1  1 = apply ReLU, 0 = pass accumulator unchanged; sampled in ACT
out_valid  output  1  sfp_out holds a completed frame
out_ready  input  1  consumer accepts the frame
sfp_out  output  psum_bw*col  packed result, same channel layout as sfp_in
sat_flag  output  col  sticky per-channel saturation indicator for the current frame
beat_cnt  output  cnt_bw  beats accepted in the current frame; saturates at all-ones

Behaviour:
- Reset/clr values: state=IDLE; accumulators=0; sfp_out=0; out_valid=0; sat_flag=0; beat_cnt=0.
- in_ready = 1 in IDLE or ACC, 0 in ACT or HOLD. This is combinational from state.
- A beat is accepted when in_valid && in_ready at a rising edge.
- States:
  - IDLE: accumulators are 0. An accepted beat performs acc += sfp_in and moves to ACC, or to ACT if in_last=1.
  - ACC: each accepted beat performs acc += sfp_in. If in_last=1 on an accepted beat, move to ACT. A cycle without in_valid holds state.
  - ACT: exactly one cycle.
    - sfp_out[k] <= (relu_en && !(acc[k] > thres)) ? 0 : acc[k].
    - out_valid <= 1; move to HOLD.
    - The comparison is signed, psum_bw wide.
  - HOLD: sfp_out and out_valid are held stable while out_ready=0.
    - When out_ready=1: out_valid <= 0; accumulators, sat_flag and beat_cnt are cleared; move to IDLE.
    - Input is not accepted in HOLD.
- Arithmetic: each channel is a signed psum_bw + psum_bw add with saturation.
  - Positive overflow clamps to 2^(psum_bw-1)-1; negative overflow clamps to -2^(psum_bw-1).
  - Any clamp sets sat_flag[k] (sticky until the frame ends, clr, or reset).
  - No wrap-around is ever produced.
- beat_cnt increments on each accepted beat, saturating at 2^cnt_bw-1 without wrapping. It is cleared on frame completion, clr, and reset.
- Latency: if the last beat is accepted at edge t, out_valid is high after edge t+1. The earliest next-frame beat is accepted at the edge after the out_ready handshake.
- in_last with in_valid=0 is ignored.
- A frame of a single beat (in_last on the first beat) is legal: IDLE goes directly to ACT.
- clr or reset during any state, including ACT or HOLD with out_valid=1, discards the frame: out_valid=0 on the next cycle and sfp_out=0.
- reset and clr asserted together: reset semantics (identical outcome).
- Channel independence: saturation or ReLU on one channel never affects another.

Test Plan:
1. Reset: hold reset 2 cycles mid-ACC with nonzero acc -> all outputs 0, in_ready=1, state IDLE.
2. 3-beat frame, col=8, relu_en=1, thres=0; ch0 inputs 5, -2, 4 and ch1 inputs -10, 3, 1 (others 0) -> ch0=7, ch1=0, others 0; out_valid 2 edges after the last beat is presented; beat_cnt=3.
3. Saturation, psum_bw=16: ch2 inputs 30000, 10000; ch3 inputs -30000, -10000; relu_en=0 -> ch2=32767, ch3=-32768, sat_flag=8'b00001100.
4. Back-pressure: out_ready=0 for 5 cycles after out_valid -> sfp_out stable, in_ready=0, in_valid beats ignored. Then out_ready=1 -> out_valid drops next cycle, in_ready=1, accumulators 0.
5. Single-beat frame with in_last on the first beat, thres=3, relu_en=1, ch0=3, ch1=4 -> ch0=0, ch1=4.
6. clr asserted in HOLD with out_valid=1 -> out_valid=0 and sfp_out=0 next cycle. A following 1-beat frame with value 9 on ch0 outputs exactly 9, with no residue from the previous frame.
